// File: rtl/gusn_pkg.sv
// Shared types and defaults for the perceptron frame loader.
// FSM state encoding, class codes and default geometry.
package gusn_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } loader_state_t;

    localparam logic [1:0] CLS_CIRCLE = 2'd2;
    localparam logic [1:0] CLS_CROSS  = 2'd3;

    localparam int DEF_COLS    = 5;
    localparam int DEF_ROWS    = 5;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/row_shift_buffer.sv
// Fill-side frame assembler: shifts COLS-bit rows into a ROWS*COLS frame.
// With FRAME_LOADER_PARITY_EN, frames holding a bad-parity row are dropped and flagged on "bad".
module row_shift_buffer
    import gusn_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [COLS:0]          row,
    input  logic                   pop,
    output logic [ROWS*COLS-1:0]   frame,
    output logic                   full,
    output logic                   bad
);

    localparam int W  = ROWS * COLS;
    localparam int CW = $clog2(ROWS);

    logic [W-1:0]  r_buf;
    logic [CW-1:0] r_cnt;
    logic          r_full;
    logic          w_last;
    logic          w_drop;

    assign w_last = push && (r_cnt == CW'(ROWS - 1));

`ifdef FRAME_LOADER_PARITY_EN
    logic r_bad;
    logic w_row_bad;

    // Even parity over pixels plus parity bit; any odd row poisons the frame.
    assign w_row_bad = ^row;
    assign w_drop    = w_last && (r_bad || w_row_bad);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bad <= 1'b0;
        end else if (w_last) begin
            r_bad <= 1'b0;
        end else if (push && w_row_bad) begin
            r_bad <= 1'b1;
        end
    end
`else
    logic w_unused_par;

    assign w_unused_par = row[COLS];
    assign w_drop       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (push) begin
            r_buf <= {r_buf[W-COLS-1:0], row[COLS-1:0]};
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // pop only happens while full, push only while not full: never together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
        end else if (pop) begin
            r_full <= 1'b0;
        end else if (w_last && !w_drop) begin
            r_full <= 1'b1;
        end
    end

    assign frame = r_buf;
    assign full  = r_full;
    assign bad   = w_drop;

endmodule

// File: rtl/frame_loader.sv
// Double-buffered row-to-frame feeder for the perceptron classifier.
// Optional row parity checking is enabled by defining FRAME_LOADER_PARITY_EN.
module frame_loader
    import gusn_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [COLS:0]          row_data,
    input  logic                   row_valid,
    output logic                   row_ready,
    output logic [ROWS*COLS-1:0]   pc_in,
    output logic                   pc_en,
    input  logic                   pc_ready,
    input  logic [1:0]             pc_out,
    output logic [1:0]             cls,
    output logic                   cls_valid,
    output logic                   err,
    output logic                   busy
);

    localparam int WIDTH = ROWS * COLS;
    localparam int TW    = $clog2(TIMEOUT + 1);

    loader_state_t r_state;
    loader_state_t w_next;

    logic [WIDTH-1:0] w_frame;
    logic [WIDTH-1:0] r_pc_in;
    logic [TW-1:0]    r_timer;
    logic [1:0]       r_cls;
    logic             r_cls_valid;
    logic             r_err;
    logic             r_par_pend;
    logic             w_full;
    logic             w_bad;
    logic             w_push;
    logic             w_pop;
    logic             w_tmo;
    logic             w_done;
    logic             w_abort;
    logic             w_par_any;
    logic             w_pc_en;
    logic             w_busy;

    assign row_ready = rst_n && !w_full;
    assign w_push    = row_valid && row_ready;

    row_shift_buffer #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_fill (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .row   (row_data),
        .pop   (w_pop),
        .frame (w_frame),
        .full  (w_full),
        .bad   (w_bad)
    );

    assign w_tmo = (r_timer == TW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_full) w_next = ISSUE;
            ISSUE:     w_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!pc_ready)  w_next = WAIT_DONE;
                else if (w_tmo) w_next = IDLE;
            end
            WAIT_DONE: begin
                if (pc_ready)   w_next = IDLE;
                else if (w_tmo) w_next = IDLE;
            end
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        w_pop   = 1'b0;
        w_done  = 1'b0;
        w_abort = 1'b0;
        w_pc_en = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            IDLE:      w_pop = w_full;
            ISSUE: begin
                w_pc_en = 1'b1;
                w_busy  = 1'b1;
            end
            WAIT_BUSY: begin
                w_pc_en = 1'b1;
                w_busy  = 1'b1;
                w_abort = pc_ready && w_tmo;
            end
            WAIT_DONE: begin
                w_pc_en = 1'b1;
                w_busy  = 1'b1;
                w_done  = pc_ready;
                w_abort = !pc_ready && w_tmo;
            end
            default: ;
        endcase
    end

    // Timer restarts on issue and again once the perceptron has gone busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (r_state == ISSUE || (r_state == WAIT_BUSY && !pc_ready)) begin
            r_timer <= '0;
        end else if ((r_state == WAIT_BUSY || r_state == WAIT_DONE) && !w_tmo) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // A parity drop that lands on a classification completion is deferred one cycle.
    assign w_par_any = w_bad || r_par_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_in     <= '0;
            r_cls       <= '0;
            r_cls_valid <= 1'b0;
            r_err       <= 1'b0;
            r_par_pend  <= 1'b0;
        end else begin
            if (w_pop)  r_pc_in <= w_frame;
            if (w_done) r_cls   <= pc_out;
            r_cls_valid <= w_done;
            r_err       <= w_abort || (w_par_any && !w_done);
            r_par_pend  <= w_par_any && w_done;
        end
    end

    assign pc_in     = r_pc_in;
    assign pc_en     = w_pc_en;
    assign busy      = w_busy;
    assign cls       = r_cls;
    assign cls_valid = r_cls_valid;
    assign err       = r_err;

endmodule

// File: tb/tb_frame_loader.sv
// Directed self-checking bench for frame_loader with a small perceptron model.
// Honours FRAME_LOADER_PARITY_EN for the parity-error scenario.
module tb_frame_loader;
    import gusn_pkg::*;

    localparam int COLS = 5;
    localparam int ROWS = 5;
    localparam int W    = 25;
    localparam logic [W-1:0] F_CROSS  = 25'h1151151;
    localparam logic [W-1:0] F_CIRCLE = 25'h0454544;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [COLS:0] row_data = '0;
    logic          row_valid = 1'b0;
    logic          row_ready;
    logic [W-1:0]  pc_in;
    logic          pc_en;
    logic          pc_ready = 1'b1;
    logic [1:0]    pc_out = 2'd0;
    logic [1:0]    cls;
    logic          cls_valid;
    logic          err;
    logic          busy;

    always #5 clk = ~clk;

    frame_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_data  (row_data),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .pc_in     (pc_in),
        .pc_en     (pc_en),
        .pc_ready  (pc_ready),
        .pc_out    (pc_out),
        .cls       (cls),
        .cls_valid (cls_valid),
        .err       (err),
        .busy      (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Perceptron model: on a pc_en rise, ready drops for 4 cycles then returns with a class.
    logic       hang = 1'b0;
    int         m_cnt = 0;
    logic       m_prev = 1'b0;
    int         en_rises = 0;
    int         en_drop_bad = 0;
    int         cv_cnt = 0;
    int         err_cnt = 0;
    int         both_cnt = 0;
    logic [1:0] cls_log[$];

    function automatic logic [1:0] classify(input logic [W-1:0] f);
        if (f == F_CROSS)  return CLS_CROSS;
        if (f == F_CIRCLE) return CLS_CIRCLE;
        return 2'd1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            pc_ready = 1'b1;
            pc_out   = 2'd0;
            m_cnt    = 0;
            m_prev   = 1'b0;
        end else begin
            if (pc_en && !m_prev) begin
                en_rises++;
                if (!hang) begin
                    pc_ready = 1'b0;
                    m_cnt    = 4;
                end
            end else if (m_cnt > 0) begin
                if (!pc_en) en_drop_bad++;
                m_cnt--;
                if (m_cnt == 0) begin
                    pc_ready = 1'b1;
                    pc_out   = classify(pc_in);
                end
            end
            m_prev = pc_en;
            if (cls_valid) begin
                cv_cnt++;
                cls_log.push_back(cls);
            end
            if (err) err_cnt++;
            if (cls_valid && err) both_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [COLS:0] mkrow(input logic [COLS-1:0] p, input logic flip);
        return {(^p) ^ flip, p};
    endfunction

    task automatic send_row(input logic [COLS:0] r, output int stalls);
        row_data  = r;
        row_valid = 1'b1;
        stalls    = 0;
        while (!row_ready && stalls < 600) begin
            tick();
            stalls++;
        end
        if (!row_ready) check("row_accept_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic send_frame(input logic [W-1:0] f, input int bad_row, output int first_stall);
        int s;
        for (int i = 0; i < ROWS; i++) begin
            send_row(mkrow(f[W-1-COLS*i -: COLS], (i == bad_row)), s);
            if (i == 0) first_stall = s;
        end
        row_valid = 1'b0;
    endtask

    task automatic wait_cls(input string tag);
        int n = 0;
        while (!cls_valid && n < 200) begin
            tick();
            n++;
        end
        check(tag, {31'd0, cls_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s, s2, n, base, e0, r0, c0;

        // Reset state
        tick();
        tick();
        check("rst_pc_in", pc_in, 32'd0);
        check("rst_pc_en", {31'd0, pc_en}, 32'd0);
        check("rst_cls", {30'd0, cls}, 32'd0);
        check("rst_cls_valid", {31'd0, cls_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_row_ready", {31'd0, row_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_row_ready", {31'd0, row_ready}, 32'd1);

        // 1: cross frame, latency and hold
        send_frame(F_CROSS, -1, s);
        check("t1_en_before_issue", {31'd0, pc_en}, 32'd0);
        tick();
        check("t1_en_issue", {31'd0, pc_en}, 32'd1);
        check("t1_pc_in", pc_in, F_CROSS);
        check("t1_busy", {31'd0, busy}, 32'd1);
        tick(); tick(); tick();
        check("t1_en_hold", {31'd0, pc_en}, 32'd1);
        check("t1_pc_in_stable", pc_in, F_CROSS);
        wait_cls("t1_cls_valid_seen");
        check("t1_cls", {30'd0, cls}, {30'd0, CLS_CROSS});
        check("t1_en_dropped", {31'd0, pc_en}, 32'd0);
        tick();
        check("t1_cls_valid_pulse", {31'd0, cls_valid}, 32'd0);
        check("t1_cv_count", cv_cnt, 32'd1);

        // 2: circle frame
        send_frame(F_CIRCLE, -1, s);
        tick();
        check("t2_pc_in", pc_in, F_CIRCLE);
        wait_cls("t2_cls_valid_seen");
        check("t2_cls", {30'd0, cls}, {30'd0, CLS_CIRCLE});

        // 3: back-to-back frames, second fills while the first is classified
        tick();
        base = cv_cnt;
        send_frame(F_CROSS, -1, s);
        check("t3_first_row_no_stall", s, 32'd0);
        send_frame(F_CIRCLE, -1, s2);
        check("t3_row6_one_stall", s2, 32'd1);
        n = 0;
        while (cv_cnt - base < 2 && n < 300) begin
            tick();
            n++;
        end
        check("t3_two_results", cv_cnt - base, 32'd2);
        if (cls_log.size() >= base + 2) begin
            check("t3_cls_first", {30'd0, cls_log[base]}, {30'd0, CLS_CROSS});
            check("t3_cls_second", {30'd0, cls_log[base+1]}, {30'd0, CLS_CIRCLE});
        end

        // 4: perceptron never goes busy -> timeout abort
        tick();
        hang = 1'b1;
        e0 = err_cnt;
        send_frame(F_CIRCLE, -1, s);
        tick();
        check("t4_en_issue", {31'd0, pc_en}, 32'd1);
        n = 0;
        while (!err && n < 400) begin
            tick();
            n++;
        end
        // 1 ISSUE cycle + 256 WAIT_BUSY cycles (timer 0..255) before err is visible
        check("t4_timeout_cycles", n, 32'd257);
        check("t4_en_dropped", {31'd0, pc_en}, 32'd0);
        check("t4_cls_unchanged", {30'd0, cls}, {30'd0, CLS_CIRCLE});
        check("t4_no_cls_valid", {31'd0, cls_valid}, 32'd0);
        tick();
        check("t4_err_pulse", {31'd0, err}, 32'd0);
        check("t4_err_count", err_cnt - e0, 32'd1);
        hang = 1'b0;
        send_frame(F_CROSS, -1, s);
        wait_cls("t4_next_cls_seen");
        check("t4_next_cls", {30'd0, cls}, {30'd0, CLS_CROSS});

        // 5: reset in the middle of a frame
        tick();
        for (int i = 0; i < 3; i++) send_row(mkrow(F_CROSS[W-1-COLS*i -: COLS], 1'b0), s);
        row_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("t5_pc_in", pc_in, 32'd0);
        check("t5_cls", {30'd0, cls}, 32'd0);
        check("t5_pc_en", {31'd0, pc_en}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_row_ready", {31'd0, row_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        send_frame(F_CIRCLE, -1, s);
        tick();
        check("t5_clean_frame", pc_in, F_CIRCLE);
        wait_cls("t5_cls_seen");
        check("t5_cls_after", {30'd0, cls}, {30'd0, CLS_CIRCLE});

        // 6: bad parity on the second row
        tick();
        e0 = err_cnt;
        r0 = en_rises;
        c0 = cv_cnt;
        send_frame(F_CROSS, 1, s);
        for (int i = 0; i < 20; i++) tick();
`ifdef FRAME_LOADER_PARITY_EN
        check("t6_err", err_cnt - e0, 32'd1);
        check("t6_no_issue", en_rises - r0, 32'd0);
        check("t6_no_cls", cv_cnt - c0, 32'd0);
`else
        check("t6_no_err", err_cnt - e0, 32'd0);
        check("t6_classified", cv_cnt - c0, 32'd1);
        check("t6_cls", {30'd0, cls}, {30'd0, CLS_CROSS});
`endif
        send_frame(F_CIRCLE, -1, s);
        wait_cls("t6_next_seen");
        check("t6_next_cls", {30'd0, cls}, {30'd0, CLS_CIRCLE});

        tick();
        check("never_both_pulses", both_cnt, 32'd0);
        check("en_held_while_busy", en_drop_bad, 32'd0);
`ifdef FRAME_LOADER_PARITY_EN
        check("total_err", err_cnt, 32'd2);
`else
        check("total_err", err_cnt, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
